// File: rtl/bus_arb.sv
// Two-master memory arbiter: an instruction fetch port (ibus) and a data port (dbus)
// share one memory port, with dbus priority bounded by a starvation limit and a grant watchdog.
module bus_arb #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_addr,
  input  logic        i_ibus_req,
  output logic [31:0] o_ibus_data,
  output logic        o_ibus_rsp,
  input  logic [31:0] i_dbus_addr,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_req,
  output logic [31:0] o_dbus_rdata,
  output logic        o_dbus_rsp,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_req,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_rsp,
  output logic [1:0]  o_owner,
  output logic        o_err
);

  // Handshake: a requester holds req and its request fields stable until its rsp;
  // rsp is a one-cycle pulse, and req may drop or re-assert the cycle after it.
  // Memory side: o_mem_req stays high for the whole grant until an i_mem_rsp pulse.

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic [3:0] SMAX    = 4'(STARVE_MAX);
  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [3:0]  streak, streak_nxt;
  logic [7:0]  wdog;
  logic        wdog_hit;

  // wdog holds the number of completed grant cycles, so the TIMEOUT-th grant cycle fires.
  assign wdog_hit = TO_EN && (wdog == TO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      streak <= 4'd0;
      wdog   <= 8'd0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      if (state == IDLE)
        wdog <= 8'd0;
      else if (wdog != 8'hFF)
        wdog <= wdog + 8'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    streak_nxt   = streak;
    o_mem_addr   = 32'd0;
    o_mem_wdata  = 32'd0;
    o_mem_sel    = 4'd0;
    o_mem_we     = 1'b0;
    o_mem_req    = 1'b0;
    o_ibus_data  = 32'd0;
    o_ibus_rsp   = 1'b0;
    o_dbus_rdata = 32'd0;
    o_dbus_rsp   = 1'b0;
    o_err        = 1'b0;
    o_owner      = state;
    case (state)
      IDLE: begin
        if (i_dbus_req && (!i_ibus_req || streak < SMAX)) begin
          state_nxt  = GNT_D;
          streak_nxt = i_ibus_req ? streak + 4'd1 : 4'd0;
        end else if (i_ibus_req) begin
          state_nxt  = GNT_I;
          streak_nxt = 4'd0;
        end
      end
      GNT_I: begin
        o_mem_req  = 1'b1;
        o_mem_addr = i_ibus_addr;
        o_mem_sel  = 4'hF;
        if (i_mem_rsp) begin
          o_ibus_rsp  = 1'b1;
          o_ibus_data = i_mem_rdata;
          state_nxt   = IDLE;
        end else if (wdog_hit) begin
          o_ibus_rsp  = 1'b1;
          o_ibus_data = 32'hDEADBEEF;
          o_err       = 1'b1;
          state_nxt   = IDLE;
        end
      end
      GNT_D: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = i_dbus_addr;
        o_mem_wdata = i_dbus_wdata;
        o_mem_sel   = i_dbus_sel;
        o_mem_we    = i_dbus_we;
        if (i_mem_rsp) begin
          o_dbus_rsp   = 1'b1;
          o_dbus_rdata = i_mem_rdata;
          state_nxt    = IDLE;
        end else if (wdog_hit) begin
          o_dbus_rsp   = 1'b1;
          o_dbus_rdata = 32'hDEADBEEF;
          o_err        = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: directed scenarios, a cycle-level owner/age model checked every
// negedge, and literal expectations for fetch, store, starvation order, timeout and reset.
module tb_bus_arb;

  localparam int SM = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dsel;
  logic        ireq, dreq, dwe, mrsp;
  logic [31:0] o_ibus_data, o_dbus_rdata, o_mem_addr, o_mem_wdata;
  logic        o_ibus_rsp, o_dbus_rsp, o_mem_we, o_mem_req, o_err;
  logic [3:0]  o_mem_sel;
  logic [1:0]  o_owner;

  logic        dreq0, mrsp0;
  logic [31:0] ibus_data0, dbus_rdata0, mem_addr0, mem_wdata0;
  logic        ibus_rsp0, dbus_rsp0, mem_we0, mem_req0, err0;
  logic [3:0]  mem_sel0;
  logic [1:0]  owner0;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  bus_arb #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_addr(iaddr), .i_ibus_req(ireq), .o_ibus_data(o_ibus_data), .o_ibus_rsp(o_ibus_rsp),
    .i_dbus_addr(daddr), .i_dbus_wdata(dwdata), .i_dbus_sel(dsel), .i_dbus_we(dwe),
    .i_dbus_req(dreq), .o_dbus_rdata(o_dbus_rdata), .o_dbus_rsp(o_dbus_rsp),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel),
    .o_mem_we(o_mem_we), .o_mem_req(o_mem_req), .i_mem_rdata(mrdata), .i_mem_rsp(mrsp),
    .o_owner(o_owner), .o_err(o_err)
  );

  bus_arb #(.STARVE_MAX(SM), .TIMEOUT(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_ibus_addr(iaddr), .i_ibus_req(1'b0), .o_ibus_data(ibus_data0), .o_ibus_rsp(ibus_rsp0),
    .i_dbus_addr(daddr), .i_dbus_wdata(dwdata), .i_dbus_sel(dsel), .i_dbus_we(dwe),
    .i_dbus_req(dreq0), .o_dbus_rdata(dbus_rdata0), .o_dbus_rsp(dbus_rsp0),
    .o_mem_addr(mem_addr0), .o_mem_wdata(mem_wdata0), .o_mem_sel(mem_sel0),
    .o_mem_we(mem_we0), .o_mem_req(mem_req0), .i_mem_rdata(mrdata), .i_mem_rsp(mrsp0),
    .o_owner(owner0), .o_err(err0)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget);
    int k = 0;
    while (o_owner == 2'b00 && k < budget) begin
      tick(1);
      k++;
    end
    check("grant_wait", 32'(o_owner != 2'b00), 32'd1);
  endtask

  // Model: owner (0 none, 1 ibus, 2 dbus), consecutive dbus wins, and age of the
  // current grant counted from 1 on its first cycle.
  int          m_own = 0, m_streak = 0, m_age = 0;
  bit          m_fin;
  logic [31:0] e_addr, e_wdata, e_idata, e_drdata;
  logic [3:0]  e_sel;
  logic        e_we, e_req, e_irsp, e_drsp, e_err;
  logic [1:0]  e_owner, prev_owner = 2'b00;
  logic [138:0] exp_v, got_v;
  logic [1:0]  got_q[$];

  always @(negedge clk) begin
    e_addr = 0; e_wdata = 0; e_sel = 0; e_we = 0; e_req = 0;
    e_idata = 0; e_irsp = 0; e_drdata = 0; e_drsp = 0; e_err = 0; e_owner = 0;
    m_fin = 0;
    if (!rst && m_own != 0) begin
      e_req   = 1'b1;
      e_owner = 2'(m_own);
      if (m_own == 1) begin
        e_addr = iaddr; e_sel = 4'hF;
      end else begin
        e_addr = daddr; e_wdata = dwdata; e_sel = dsel; e_we = dwe;
      end
      if (mrsp || (TO != 0 && m_age == TO)) begin
        m_fin = 1;
        if (m_own == 1) begin
          e_irsp = 1; e_idata = mrsp ? mrdata : 32'hDEADBEEF;
        end else begin
          e_drsp = 1; e_drdata = mrsp ? mrdata : 32'hDEADBEEF;
        end
        e_err = !mrsp;
      end
    end
    exp_v = {e_addr, e_wdata, e_sel, e_we, e_req, e_idata, e_irsp, e_drdata, e_drsp, e_owner, e_err};
    got_v = {o_mem_addr, o_mem_wdata, o_mem_sel, o_mem_we, o_mem_req, o_ibus_data, o_ibus_rsp,
             o_dbus_rdata, o_dbus_rsp, o_owner, o_err};
    n_checks++;
    if (got_v !== exp_v) begin
      n_errs++;
      $display("FAIL cycle_model @%0t: got %h expected %h", $time, got_v, exp_v);
    end
    if (prev_owner == 2'b00 && o_owner != 2'b00) got_q.push_back(o_owner);
    prev_owner = o_owner;
    if (rst) begin
      m_own = 0; m_streak = 0; m_age = 0;
    end else if (m_own == 0) begin
      if (dreq && (!ireq || m_streak < SM)) begin
        m_own = 2; m_age = 1;
        m_streak = ireq ? ((m_streak + 1 > SM) ? SM : m_streak + 1) : 0;
      end else if (ireq) begin
        m_own = 1; m_age = 1; m_streak = 0;
      end
    end else if (m_fin) begin
      m_own = 0;
    end else begin
      m_age++;
    end
  end

  logic [1:0] exp_q[$];

  initial begin
    rst = 1; iaddr = 0; daddr = 0; dwdata = 0; mrdata = 0; dsel = 0;
    ireq = 0; dreq = 0; dwe = 0; mrsp = 0; dreq0 = 0; mrsp0 = 0;
    tick(2);
    check("reset_owner", 32'(o_owner), 32'd0);
    check("reset_mem_req", 32'(o_mem_req), 32'd0);
    rst = 0;
    tick(1);

    // Single fetch, memory answers on the third grant cycle
    iaddr = 32'h100; ireq = 1;
    tick(1);
    check("fetch_owner", 32'(o_owner), 32'd1);
    tick(2);
    mrsp = 1; mrdata = 32'h13;
    #1;
    check("fetch_addr", o_mem_addr, 32'h100);
    check("fetch_we", 32'(o_mem_we), 32'd0);
    check("fetch_rsp", 32'(o_ibus_rsp), 32'd1);
    check("fetch_data", o_ibus_data, 32'h13);
    tick(1);
    mrsp = 0; ireq = 0;
    check("fetch_idle", 32'(o_owner), 32'd0);
    tick(1);

    // Store
    daddr = 32'h2000; dwdata = 32'hA5A5A5A5; dsel = 4'b0011; dwe = 1; dreq = 1;
    tick(1);
    check("store_addr", o_mem_addr, 32'h2000);
    check("store_wdata", o_mem_wdata, 32'hA5A5A5A5);
    check("store_sel", 32'(o_mem_sel), 32'h3);
    check("store_we", 32'(o_mem_we), 32'd1);
    check("store_owner", 32'(o_owner), 32'd2);
    mrsp = 1; mrdata = 32'h55;
    #1;
    check("store_rsp", 32'(o_dbus_rsp), 32'd1);
    tick(1);
    mrsp = 0; dreq = 0; dwe = 0;
    tick(1);

    // Starvation: both requesters held, one-cycle memory latency
    iaddr = 32'h180; daddr = 32'h2400;
    ireq = 1; dreq = 1;
    got_q.delete();
    for (int g = 0; g < 10; g++) begin
      wait_grant(5);
      mrsp = 1; mrdata = $urandom;
      tick(1);
      mrsp = 0;
    end
    ireq = 0; dreq = 0;
    exp_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    check("starve_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int g = 0; g < 10 && g < got_q.size(); g++)
      check("starve_order", 32'(got_q[g]), 32'(exp_q[g]));
    tick(1);

    // Timeout; requester drops req mid-grant without aborting it
    daddr = 32'h3000; dreq = 1;
    tick(1);
    check("to_owner", 32'(o_owner), 32'd2);
    tick(1);
    dreq = 0;
    tick(5);
    check("to_early_err", 32'(o_err), 32'd0);
    tick(1);
    check("to_rsp", 32'(o_dbus_rsp), 32'd1);
    check("to_err", 32'(o_err), 32'd1);
    check("to_data", o_dbus_rdata, 32'hDEADBEEF);
    tick(1);
    check("to_idle", 32'(o_owner), 32'd0);
    tick(1);

    // Memory response on the timeout cycle wins
    dreq = 1;
    tick(8);
    mrsp = 1; mrdata = 32'h1234;
    #1;
    check("tie_rsp", 32'(o_dbus_rsp), 32'd1);
    check("tie_err", 32'(o_err), 32'd0);
    check("tie_data", o_dbus_rdata, 32'h1234);
    tick(1);
    mrsp = 0; dreq = 0;
    tick(1);

    // Reset in the middle of a dbus grant
    dreq = 1; dwe = 1;
    tick(1);
    check("rst_pre_req", 32'(o_mem_req), 32'd1);
    #2 rst = 1;
    #1;
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_owner", 32'(o_owner), 32'd0);
    tick(1);
    rst = 0; dreq = 0; dwe = 0; ireq = 1; iaddr = 32'h400; mrsp = 1; mrdata = 32'h99;
    #1;
    check("rst_late_drsp", 32'(o_dbus_rsp), 32'd0);
    check("rst_late_irsp", 32'(o_ibus_rsp), 32'd0);
    tick(1);
    mrsp = 0;
    check("rst_first_arb", 32'(o_owner), 32'd1);
    mrsp = 1; mrdata = 32'h77;
    #1;
    check("rst_fetch_data", o_ibus_data, 32'h77);
    tick(1);
    mrsp = 0; ireq = 0;
    tick(1);

    // Watchdog disabled: grant waits indefinitely
    daddr = 32'h5000; dreq0 = 1;
    tick(1);
    dreq0 = 0;
    for (int c = 0; c < 300; c++) begin
      check("to0_wait", {29'd0, owner0, err0 | dbus_rsp0}, {29'd0, 2'b10, 1'b0});
      tick(1);
    end
    mrsp0 = 1; mrdata = 32'hCAFE;
    #1;
    check("to0_rsp", 32'(dbus_rsp0), 32'd1);
    check("to0_data", dbus_rdata0, 32'hCAFE);
    tick(1);
    mrsp0 = 0;
    check("to0_idle", 32'(owner0), 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
